// File: rtl/ksz_bus_master.sv
// KSZ8851 16-bit host-bus engine: command-address cycle then one data read/write cycle.
// Optional KSZ_BYTE_SWAP_EN swaps data bytes on the bus (never the command word).
`timescale 1ns/1ps
module ksz_bus_master #(
  parameter int PULSE_CYCLES    = 2,
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic        clk40m,
  input  logic        reset,
  input  logic [7:0]  offset,
  input  logic        length,
  input  logic        WR,
  input  logic [15:0] writeData,
  input  logic        NewCommand,
  output logic [15:0] readData,
  output logic [3:0]  state,
  output logic        eth_cmd,
  output logic        eth_csn,
  output logic        eth_rdn,
  output logic        eth_wrn,
  output logic [15:0] sd_out,
  output logic        sd_oe,
  input  logic [15:0] sd_in
);

  typedef enum logic [3:0] {
    ADDR0  = 4'd0,
    ADDR1  = 4'd1,
    ADDR2  = 4'd2,
    READ0  = 4'd3,
    READ1  = 4'd4,
    READ2  = 4'd5,
    WRITE0 = 4'd6,
    WRITE1 = 4'd7,
    WRITE2 = 4'd8,
    WAIT   = 4'd9
  } phase_t;

  localparam logic [3:0] PULSE_LD    = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] RECOVERY_LD = 4'(RECOVERY_CYCLES - 1);

  phase_t      phase_q, phase_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  off_q;
  logic        len_q;
  logic        wr_q;
  logic [15:0] wdata_q;

  logic        cmd_d, csn_d, rdn_d, wrn_d, oe_d;
  logic [15:0] sd_out_d;

  function automatic logic [15:0] cmd_word(input logic [7:0] off, input logic len);
    logic [3:0] be;
    if (len) be = off[1] ? 4'b1100 : 4'b0011;
    else     be = 4'b0001 << off[1:0];
    return {be, 4'b0000, off[7:2], 2'b00};
  endfunction

  function automatic logic [15:0] data_swap(input logic [15:0] d);
`ifdef KSZ_BYTE_SWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  assign state = phase_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (phase_q)
      WAIT:   if (NewCommand) phase_d = ADDR0;
      ADDR0:  begin phase_d = ADDR1; cnt_d = PULSE_LD; end
      ADDR1:  if (cnt_q == 4'd0) phase_d = ADDR2; else cnt_d = cnt_q - 4'd1;
      ADDR2:  phase_d = wr_q ? WRITE0 : READ0;
      READ0:  begin phase_d = READ1; cnt_d = PULSE_LD; end
      READ1:  if (cnt_q == 4'd0) begin phase_d = READ2; cnt_d = RECOVERY_LD; end
              else cnt_d = cnt_q - 4'd1;
      WRITE0: begin phase_d = WRITE1; cnt_d = PULSE_LD; end
      WRITE1: if (cnt_q == 4'd0) begin phase_d = WRITE2; cnt_d = RECOVERY_LD; end
              else cnt_d = cnt_q - 4'd1;
      READ2, WRITE2:
              if (cnt_q == 4'd0) phase_d = NewCommand ? ADDR0 : WAIT;
              else cnt_d = cnt_q - 4'd1;
      default: begin phase_d = WAIT; cnt_d = 4'd0; end
    endcase
  end

  // Pin values are decoded from the upcoming phase so every pin comes straight off a flop.
  always_comb begin
    cmd_d    = 1'b0;
    csn_d    = 1'b1;
    rdn_d    = 1'b1;
    wrn_d    = 1'b1;
    oe_d     = 1'b0;
    sd_out_d = sd_out;
    case (phase_d)
      ADDR0: begin
        cmd_d = 1'b1; csn_d = 1'b0; oe_d = 1'b1;
        sd_out_d = cmd_word(offset, length);
      end
      ADDR1: begin
        cmd_d = 1'b1; csn_d = 1'b0; oe_d = 1'b1; wrn_d = 1'b0;
        if (phase_q == ADDR0) sd_out_d = cmd_word(offset, length);
      end
      ADDR2: begin
        cmd_d = 1'b1; csn_d = 1'b0; oe_d = 1'b1;
        sd_out_d = cmd_word(off_q, len_q);
      end
      READ0:  csn_d = 1'b0;
      READ1:  begin csn_d = 1'b0; rdn_d = 1'b0; end
      WRITE0: begin
        csn_d = 1'b0; oe_d = 1'b1;
        sd_out_d = data_swap(writeData);
      end
      WRITE1: begin
        csn_d = 1'b0; oe_d = 1'b1; wrn_d = 1'b0;
        if (phase_q == WRITE0) sd_out_d = data_swap(wdata_q);
      end
      WRITE2: oe_d = (phase_q == WRITE1);
      default: ;
    endcase
  end

  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      phase_q  <= WAIT;
      cnt_q    <= 4'd0;
      off_q    <= 8'd0;
      len_q    <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= 16'd0;
      readData <= 16'd0;
      eth_cmd  <= 1'b0;
      eth_csn  <= 1'b1;
      eth_rdn  <= 1'b1;
      eth_wrn  <= 1'b1;
      sd_oe    <= 1'b0;
      sd_out   <= 16'd0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      if (phase_q == ADDR0) begin
        off_q <= offset;
        len_q <= length;
        wr_q  <= WR;
      end
      // writeData is taken as late as possible so it may depend on the previous readData.
      if (phase_q == ADDR2) wdata_q <= writeData;
      if (phase_q == READ1 && cnt_q == 4'd0) readData <= data_swap(sd_in);
      eth_cmd <= cmd_d;
      eth_csn <= csn_d;
      eth_rdn <= rdn_d;
      eth_wrn <= wrn_d;
      sd_oe   <= oe_d;
      sd_out  <= sd_out_d;
    end
  end

endmodule

// File: tb/tb_ksz_bus_master.sv
// Directed bench for ksz_bus_master: read, write, back-to-back read-modify-write,
// byte read and reset abort, with hand-computed expected values.
`timescale 1ns/1ps
module tb_ksz_bus_master;

  logic        clk40m = 1'b0;
  logic        reset;
  logic [7:0]  offset;
  logic        length;
  logic        WR;
  logic [15:0] writeData;
  logic        NewCommand;
  logic [15:0] readData;
  logic [3:0]  state;
  logic        eth_cmd, eth_csn, eth_rdn, eth_wrn;
  logic [15:0] sd_out;
  logic        sd_oe;
  logic [15:0] sd_in;

  int checks = 0;
  int errors = 0;

`ifdef KSZ_BYTE_SWAP_EN
  localparam logic [15:0] EXP_RD1  = 16'h7288;
  localparam logic [15:0] EXP_WD2  = 16'hAB89;
  localparam logic [15:0] EXP_RD3  = 16'h3412;
  localparam logic [15:0] EXP_WD3  = 16'h1234;
  localparam logic [15:0] EXP_RD4  = 16'hA500;
`else
  localparam logic [15:0] EXP_RD1  = 16'h8872;
  localparam logic [15:0] EXP_WD2  = 16'h89AB;
  localparam logic [15:0] EXP_RD3  = 16'h1234;
  localparam logic [15:0] EXP_WD3  = 16'h3214;
  localparam logic [15:0] EXP_RD4  = 16'h00A5;
`endif

  ksz_bus_master #(.PULSE_CYCLES(2), .RECOVERY_CYCLES(2)) dut (
    .clk40m(clk40m), .reset(reset), .offset(offset), .length(length), .WR(WR),
    .writeData(writeData), .NewCommand(NewCommand), .readData(readData), .state(state),
    .eth_cmd(eth_cmd), .eth_csn(eth_csn), .eth_rdn(eth_rdn), .eth_wrn(eth_wrn),
    .sd_out(sd_out), .sd_oe(sd_oe), .sd_in(sd_in)
  );

  always #12.5 clk40m = ~clk40m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // per-transaction observations
  int          n_cyc, wrn_a, wrn_w, rdn_n;
  logic [15:0] cw, wd_seen, rd_r2;
  logic        cw_ok, pins_ok, oe_ok, got_r2;
  logic [1:0]  w2_oe;
  logic [3:0]  end_state;

  task automatic wait_state(input logic [3:0] target, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (state == target) break;
      @(negedge clk40m);
    end
    check(tag, 32'(state), 32'(target));
  endtask

  // Called at a negedge where state is Addr0; follows the transaction until Wait or a new Addr0.
  task automatic watch(input logic drop_nc);
    n_cyc = 0; wrn_a = 0; wrn_w = 0; rdn_n = 0;
    cw = sd_out; wd_seen = 16'hxxxx; rd_r2 = 16'hxxxx;
    cw_ok = 1'b1; pins_ok = 1'b1; oe_ok = 1'b1; got_r2 = 1'b0; w2_oe = 2'b00;
    for (int i = 0; i < 40; i++) begin
      n_cyc++;
      if (state <= 4'd2 && (sd_out !== cw || sd_oe !== 1'b1)) cw_ok = 1'b0;
      if (eth_cmd !== (state <= 4'd2)) pins_ok = 1'b0;
      if (eth_csn !== (state == 4'd5 || state == 4'd8 || state == 4'd9)) pins_ok = 1'b0;
      if (state == 4'd1 && !eth_wrn) wrn_a++;
      if (state == 4'd7 && !eth_wrn) wrn_w++;
      if (!eth_rdn) rdn_n++;
      if (state == 4'd6) wd_seen = sd_out;
      if ((state == 4'd6 || state == 4'd7) && sd_oe !== 1'b1) oe_ok = 1'b0;
      if ((state == 4'd3 || state == 4'd4 || state == 4'd5) && sd_oe !== 1'b0) oe_ok = 1'b0;
      if (state == 4'd8) w2_oe = {w2_oe[0], sd_oe};
      if (state == 4'd5 && !got_r2) begin rd_r2 = readData; got_r2 = 1'b1; end
      if (i == 0 && drop_nc) NewCommand = 1'b0;
      @(negedge clk40m);
      if (state == 4'd9 || state == 4'd0) break;
    end
    end_state = state;
  endtask

  initial begin
    reset = 1'b0; offset = 8'h00; length = 1'b0; WR = 1'b0;
    writeData = 16'h0000; NewCommand = 1'b0; sd_in = 16'h0000;
    repeat (3) @(negedge clk40m);
    check("rst_state", 32'(state), 32'h9);
    check("rst_pins", {28'd0, eth_csn, eth_rdn, eth_wrn, eth_cmd}, 32'hE);
    check("rst_oe", 32'(sd_oe), 32'h0);
    check("rst_sdout", 32'(sd_out), 32'h0);
    check("rst_rdata", 32'(readData), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk40m);
    check("idle_state", 32'(state), 32'h9);

    // word read at C0
    WR = 1'b0; offset = 8'hC0; length = 1'b1; sd_in = 16'h8872; NewCommand = 1'b1;
    wait_state(4'd0, "rd1_start");
    watch(1'b1);
    check("rd1_cmdword", 32'(cw), 32'h30C0);
    check("rd1_cmd_held", 32'(cw_ok), 32'h1);
    check("rd1_pins", 32'(pins_ok), 32'h1);
    check("rd1_wrn_addr", 32'(wrn_a), 32'd2);
    check("rd1_rdn", 32'(rdn_n), 32'd2);
    check("rd1_rdata_r2", 32'(rd_r2), 32'(EXP_RD1));
    check("rd1_len", 32'(n_cyc + 1), 32'd10);  // +1: Wait cycle that accepts the command
    check("rd1_end", 32'(end_state), 32'h9);
    check("rd1_oe", 32'(oe_ok), 32'h1);

    // word write at 10
    WR = 1'b1; offset = 8'h10; writeData = 16'h89AB; NewCommand = 1'b1;
    wait_state(4'd0, "wr2_start");
    watch(1'b1);
    check("wr2_cmdword", 32'(cw), 32'h3010);
    check("wr2_cmd_held", 32'(cw_ok), 32'h1);
    check("wr2_data", 32'(wd_seen), 32'(EXP_WD2));
    check("wr2_oe", 32'(oe_ok), 32'h1);
    check("wr2_w2_oe", 32'(w2_oe), 32'h2);
    check("wr2_wrn_addr", 32'(wrn_a), 32'd2);
    check("wr2_wrn_data", 32'(wrn_w), 32'd2);
    check("wr2_rdn", 32'(rdn_n), 32'd0);
    check("wr2_pins", 32'(pins_ok), 32'h1);
    check("wr2_rdata_kept", 32'(readData), 32'(EXP_RD1));
    check("wr2_end", 32'(end_state), 32'h9);

    // back-to-back read then read-modify-write at F6
    WR = 1'b0; offset = 8'hF6; sd_in = 16'h1234; writeData = 16'h0000; NewCommand = 1'b1;
    wait_state(4'd0, "b2b_start");
    watch(1'b0);
    check("b2b_no_wait", 32'(end_state), 32'h0);
    check("b2b_rdata", 32'(readData), 32'(EXP_RD3));
    WR = 1'b1;
    writeData = (readData & ~16'h0020) | 16'h2000;
    watch(1'b1);
    check("b2b_cmdword", 32'(cw), 32'hC0F4);
    check("b2b_wdata", 32'(wd_seen), 32'(EXP_WD3));
    check("b2b_end", 32'(end_state), 32'h9);

    // byte read at 93
    WR = 1'b0; offset = 8'h93; length = 1'b0; sd_in = 16'h00A5; NewCommand = 1'b1;
    wait_state(4'd0, "byte_start");
    watch(1'b1);
    check("byte_cmdword", 32'(cw), 32'h8090);
    check("byte_rdata", 32'(readData), 32'(EXP_RD4));
    check("byte_end", 32'(end_state), 32'h9);

    // reset abort during Write1
    WR = 1'b1; offset = 8'h10; length = 1'b1; writeData = 16'h5555; NewCommand = 1'b1;
    wait_state(4'd0, "abort_start");
    NewCommand = 1'b0;
    wait_state(4'd7, "abort_write1");
    reset = 1'b0;
    @(posedge clk40m);
    #1;
    check("abort_state", 32'(state), 32'h9);
    check("abort_pins", {28'd0, eth_csn, eth_rdn, eth_wrn, eth_cmd}, 32'hE);
    check("abort_oe", 32'(sd_oe), 32'h0);
    check("abort_rdata", 32'(readData), 32'h0);
    @(negedge clk40m);
    reset = 1'b1;
    repeat (3) @(negedge clk40m);
    check("abort_idle", 32'(state), 32'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
